// File: rtl/keysched_pkg.sv
// Shared types and constants for the round-key scheduler.
// State encoding, default geometry, LFSR taps and permutation helpers.
package keysched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM,
    ZERO
  } ks_state_e;

  localparam int KEY_W_DEF  = 56;
  localparam int RK_W_DEF   = 48;
  localparam int ROUNDS_DEF = 16;
  localparam int ROT_DEF    = 1;
  localparam int PSTEP_DEF  = 7;

  localparam logic [47:0] LFSR_TAPS_DEF = 48'hC000_0018_0000;

  function automatic int gcd(input int a, input int b);
    int x;
    int y;
    int t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Source bit feeding output bit i of the round-key permutation.
  function automatic int perm_src(input int i, input int step, input int w);
    return (i * step) % w;
  endfunction

endpackage

// File: rtl/rk_permute.sv
// Combinational round-key bit permutation: out[i] = in[(i*PSTEP) mod RK_W].
// PSTEP must be coprime with RK_W so the mapping is a bijection.
module rk_permute
  import keysched_pkg::*;
#(
  parameter int RK_W  = RK_W_DEF,
  parameter int PSTEP = PSTEP_DEF
) (
  input  logic [RK_W-1:0] in_i,
  output logic [RK_W-1:0] out_o
);

  if (gcd(PSTEP, RK_W) != 1) begin : g_bad_step
    $error("rk_permute: PSTEP must be coprime with RK_W");
  end

  for (genvar i = 0; i < RK_W; i++) begin : g_bit
    assign out_o[i] = in_i[perm_src(i, PSTEP, RK_W)];
  end

endmodule

// File: rtl/round_key_sched.sv
// Round-key scheduler: expands a master key into ROUNDS keys, streams them.
// Optional KEYSCHED_ZEROIZE_EN adds a zeroize input and a buffer-wipe state.
module round_key_sched
  import keysched_pkg::*;
#(
  parameter int              KEY_W     = KEY_W_DEF,
  parameter int              RK_W      = RK_W_DEF,
  parameter int              ROUNDS    = ROUNDS_DEF,
  parameter int              ROT       = ROT_DEF,
  parameter int              PSTEP     = PSTEP_DEF,
  parameter logic [RK_W-1:0] LFSR_TAPS = RK_W'(LFSR_TAPS_DEF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KEY_W-1:0]          key_in,
  input  logic                      key_load,
  output logic                      key_rdy,
  input  logic                      start,
  input  logic                      decrypt,
  output logic [RK_W-1:0]           rk_data,
  output logic [$clog2(ROUNDS)-1:0] rk_idx,
  output logic                      rk_last,
  output logic                      rk_valid,
  input  logic                      rk_ready,
  output logic                      sched_rdy,
`ifdef KEYSCHED_ZEROIZE_EN
  input  logic                      zeroize,
`endif
  output logic                      done
);

  localparam int             IW   = $clog2(ROUNDS);
  localparam logic [IW-1:0]  LAST = IW'(ROUNDS - 1);

  if (RK_W > KEY_W || ROUNDS < 2 || ROUNDS > 64 ||
      ROT < 1 || ROT >= KEY_W) begin : g_bad_cfg
    $error("round_key_sched: illegal parameter set");
  end

  ks_state_e        state_q, state_d;
  logic [KEY_W-1:0] k_q, k_d;
  logic [RK_W-1:0]  l_q, l_d;
  logic [RK_W-1:0]  buf_q [ROUNDS];
  logic [IW-1:0]    cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             we;
  logic [RK_W-1:0]  wdata;
  logic [RK_W-1:0]  perm;
  logic             load_ok;
  logic             beat;
  logic             at_end;

  rk_permute #(
    .RK_W  (RK_W),
    .PSTEP (PSTEP)
  ) u_perm (
    .in_i  (k_q[KEY_W-1 -: RK_W]),
    .out_o (perm)
  );

  assign key_rdy   = (state_q == IDLE) || (state_q == READY);
  assign sched_rdy = (state_q == READY);
  assign load_ok   = key_load && key_rdy;
  assign beat      = valid_q && rk_ready;
  assign at_end    = dec_q ? (cnt_q == '0) : (cnt_q == LAST);
  assign rk_data   = buf_q[cnt_q];
  assign rk_idx    = cnt_q;
  assign rk_last   = valid_q && at_end;
  assign rk_valid  = valid_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    l_d     = l_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    we      = 1'b0;
    wdata   = perm ^ l_q;
    unique case (state_q)
      IDLE, READY: begin
        // a new key takes priority over a simultaneous start
        if (load_ok) begin
          state_d = EXPAND;
          k_d     = key_in;
          l_d     = (key_in[RK_W-1:0] == '0) ? '1 : key_in[RK_W-1:0];
          cnt_d   = '0;
        end else if (start && state_q == READY) begin
          state_d = STREAM;
          dec_d   = decrypt;
          cnt_d   = decrypt ? LAST : '0;
          valid_d = 1'b1;
        end
      end
      EXPAND: begin
        we  = 1'b1;
        k_d = {k_q[KEY_W-ROT-1:0], k_q[KEY_W-1 -: ROT]};
        l_d = {l_q[RK_W-2:0], ^(l_q & LFSR_TAPS)};
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STREAM: begin
        if (beat) begin
          if (at_end) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = READY;
          end else begin
            cnt_d = dec_q ? cnt_q - 1'b1 : cnt_q + 1'b1;
          end
        end
      end
      ZERO: begin
        we    = 1'b1;
        wdata = '0;
        k_d   = '0;
        l_d   = '0;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef KEYSCHED_ZEROIZE_EN
    if (zeroize && state_q != ZERO) begin
      state_d = ZERO;
      cnt_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
      we      = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      l_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < ROUNDS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      l_q     <= l_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (we) begin
        buf_q[cnt_q] <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_round_key_sched.sv
// Directed bench for round_key_sched: expansion, stream order, stalls, reset.
// Covers the zeroize path when KEYSCHED_ZEROIZE_EN is defined.
module tb_round_key_sched;

  localparam int KW = 56;
  localparam int RW = 48;
  localparam int NR = 16;
  localparam logic [RW-1:0] TAPS   = 48'hC000_0018_0000;
  localparam logic [KW-1:0] KEY_A  = 56'hB9D1CF565FB5A3;
  localparam logic [KW-1:0] KEY_Z  = 56'hAB000000000000;
  localparam logic [RW-1:0] Z_BUF0 = 48'h7CFF_F7FF_DFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic          key_load = 1'b0;
  logic          key_rdy;
  logic          start = 1'b0;
  logic          decrypt = 1'b0;
  logic [RW-1:0] rk_data;
  logic [3:0]    rk_idx;
  logic          rk_last;
  logic          rk_valid;
  logic          rk_ready = 1'b0;
  logic          sched_rdy;
  logic          done;
`ifdef KEYSCHED_ZEROIZE_EN
  logic          zeroize = 1'b0;
`endif

  always #5 clk = ~clk;

  round_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_load  (key_load),
    .key_rdy   (key_rdy),
    .start     (start),
    .decrypt   (decrypt),
    .rk_data   (rk_data),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .sched_rdy (sched_rdy),
`ifdef KEYSCHED_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .done      (done)
  );

  int            n_chk = 0;
  int            n_pass = 0;
  logic [RW-1:0] model [NR];
  logic [RW-1:0] enc   [NR];
  logic [RW-1:0] seen  [NR];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic void build_model(input logic [KW-1:0] key);
    logic [KW-1:0] k;
    logic [RW-1:0] l;
    logic [RW-1:0] t;
    logic [RW-1:0] p;
    logic          fb;
    k = key;
    l = key[RW-1:0];
    if (l == '0) l = {RW{1'b1}};
    for (int r = 0; r < NR; r++) begin
      t = k[KW-1:KW-RW];
      for (int i = 0; i < RW; i++) p[i] = t[(i * 7) % RW];
      model[r] = p ^ l;
      k = {k[KW-2:0], k[KW-1]};
      fb = 1'b0;
      for (int j = 0; j < RW; j++) if (TAPS[j]) fb = fb ^ l[j];
      l = {l[RW-2:0], fb};
    end
  endfunction

  task automatic load_key(input logic [KW-1:0] key, input logic with_start);
    int n;
    key_in = key;
    key_load = 1'b1;
    start = with_start;
    decrypt = 1'b0;
    @(posedge clk); #1;
    key_load = 1'b0;
    start = 1'b0;
    n = 1;
    chk("exp_busy", 64'(key_rdy), 64'(0));
    chk("exp_novalid", 64'(rk_valid), 64'(0));
    chk("exp_notready", 64'(sched_rdy), 64'(0));
    while (!sched_rdy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("load_lat", 64'(n), 64'(17));
  endtask

  task automatic run_stream(input logic dec, input logic stall, input logic poke);
    int            nb;
    int            ndone;
    logic          pst;
    logic [RW-1:0] pd;
    logic [3:0]    pi;
    logic          r;
    nb = 0;
    ndone = 0;
    pst = 1'b0;
    pd = '0;
    pi = '0;
    decrypt = dec;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    decrypt = ~dec;
    for (int c = 0; c < 200 && nb < NR; c++) begin
      r = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      rk_ready = r;
      if (poke) begin
        key_load = (c == 2);
        key_in = 56'hFFEEDDCCBBAA99;
      end
      if (!stall) chk("no_bubble", 64'(rk_valid), 64'(1));
      if (pst) begin
        chk("stall_data", 64'(rk_data), 64'(pd));
        chk("stall_idx", 64'(rk_idx), 64'(pi));
      end
      if (done) ndone++;
      if (rk_valid && r) begin
        chk("idx", 64'(rk_idx), 64'(dec ? NR - 1 - nb : nb));
        chk("last", 64'(rk_last), 64'(nb == NR - 1));
        seen[nb] = rk_data;
        nb++;
      end
      pst = rk_valid && !r;
      pd = rk_data;
      pi = rk_idx;
      @(posedge clk); #1;
    end
    rk_ready = 1'b0;
    key_load = 1'b0;
    chk("beats", 64'(nb), 64'(NR));
    chk("early_done", 64'(ndone), 64'(0));
    chk("done", 64'(done), 64'(1));
    chk("valid_off", 64'(rk_valid), 64'(0));
    chk("ready_back", 64'(sched_rdy), 64'(1));
    @(posedge clk); #1;
    chk("done_pulse", 64'(done), 64'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_rdy", 64'(key_rdy), 64'(1));
    chk("rst_sched", 64'(sched_rdy), 64'(0));
    chk("rst_valid", 64'(rk_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_last", 64'(rk_last), 64'(0));
    chk("rst_data", 64'(rk_data), 64'(0));
    chk("rst_idx", 64'(rk_idx), 64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_start", 64'(rk_valid), 64'(0));

    build_model(KEY_A);
    load_key(KEY_A, 1'b0);
    run_stream(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NR; k++) begin
      enc[k] = seen[k];
      chk("enc_key", 64'(seen[k]), 64'(model[k]));
    end

    run_stream(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < NR; k++)
      chk("dec_key", 64'(seen[k]), 64'(enc[NR - 1 - k]));

    run_stream(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NR; k++)
      chk("stall_key", 64'(seen[k]), 64'(model[k]));

    build_model(KEY_Z);
    load_key(KEY_Z, 1'b1);
    run_stream(1'b0, 1'b0, 1'b0);
    chk("zero_seed", 64'(seen[0]), 64'(Z_BUF0));
    for (int k = 0; k < NR; k++)
      chk("zkey", 64'(seen[k]), 64'(model[k]));

    decrypt = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(rk_valid), 64'(0));
    chk("arst_sched", 64'(sched_rdy), 64'(0));
    chk("arst_key_rdy", 64'(key_rdy), 64'(1));
    chk("arst_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    rk_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_rst_start", 64'(rk_valid), 64'(0));
    chk("post_rst_sched", 64'(sched_rdy), 64'(0));

`ifdef KEYSCHED_ZEROIZE_EN
    begin
      int n;
      load_key(KEY_A, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rk_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      zeroize = 1'b1;
      @(posedge clk); #1;
      zeroize = 1'b0;
      rk_ready = 1'b0;
      chk("zz_valid", 64'(rk_valid), 64'(0));
      chk("zz_key_rdy", 64'(key_rdy), 64'(0));
      n = 0;
      key_in = KEY_A;
      while (!key_rdy && n < 40) begin
        key_load = (n < 10);
        @(posedge clk); #1;
        n++;
      end
      key_load = 1'b0;
      chk("zz_cycles", 64'(n), 64'(16));
      chk("zz_data", 64'(rk_data), 64'(0));
      chk("zz_sched", 64'(sched_rdy), 64'(0));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
